accum_bank: RTL and testbench

//   Receive side of the crossbar output interface: one lane per crossbar destination FIFO.
//   - Accumulates each arriving DATA_PACKET into an on-chip partial-sum entry selected by packet.index.
//   - On request, drains all partial sums to the writeback stage over a valid/ready stream, then clears them.
//   - Sits between Xbar (out_packet/out_valid) and output writeback.

---
 rtl/accum_bank_pkg.sv | 22 ++
 rtl/accum_lane.sv | 83 ++++++++
 rtl/accum_bank.sv | 134 +++++++++++++
 tb/tb_accum_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_bank_pkg.sv
// Shared types for the crossbar receive-side accumulator bank.
// Optional build macro ACCUM_SAT_EN (used by accum_lane) selects saturating accumulation.
package accum_bank_pkg;

  localparam int unsigned NUM_DST = 4;   // crossbar destination count
  localparam int unsigned DATA_W  = 32;  // packet payload width
  localparam int unsigned INDEX_W = 8;   // packet index width

  typedef struct packed {
    logic               valid;
    logic [INDEX_W-1:0] index;
    logic [DATA_W-1:0]  data;
  } data_packet_t;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StDrain,
    StClear
  } acc_state_e;

endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: Depth signed partial sums, S1 register + S2 add/write pipeline,
// S2->S1 forwarding for back-to-back hits on one entry, single-cycle clear.
// Build macro ACCUM_SAT_EN: saturating add; otherwise two's-complement wrap-around.
module accum_lane
  import accum_bank_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned AccW  = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  valid_i,
  input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] entry_i,
  input  logic [DATA_W-1:0]                     data_i,
  input  logic                                  clear_i,
  input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] rd_entry_i,
  output logic [AccW-1:0]                       rd_data_o,
  output logic                                  busy_o
);

  localparam int unsigned EntryW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AccW-1:0]   mem_q [Depth];
  logic [AccW-1:0]   mem_d [Depth];
  logic              s1_valid_q, s1_valid_d;
  logic [EntryW-1:0] s1_entry_q, s1_entry_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [AccW-1:0]   s1_acc_q, s1_acc_d;
  logic [AccW-1:0]   data_ext;
  logic [AccW:0]     sum_wide;
  logic [AccW-1:0]   sum;

  // S2 adder: one guard bit detects signed overflow
  always_comb begin
    data_ext = AccW'($signed(s1_data_q));
    sum_wide = {s1_acc_q[AccW-1], s1_acc_q} + {data_ext[AccW-1], data_ext};
    sum      = sum_wide[AccW-1:0];
`ifdef ACCUM_SAT_EN
    if (sum_wide[AccW] != sum_wide[AccW-1]) begin
      sum = sum_wide[AccW] ? {1'b1, {(AccW-1){1'b0}}} : {1'b0, {(AccW-1){1'b1}}};
    end
`endif
  end

  // S1 capture; an entry still in S2 is taken from the adder, not the stale array
  always_comb begin
    s1_valid_d = valid_i;
    s1_entry_d = entry_i;
    s1_data_d  = data_i;
    s1_acc_d   = (s1_valid_q && (s1_entry_q == entry_i)) ? sum : mem_q[entry_i];
  end

  // Entry array next state: clear wins; otherwise S2 write-back
  always_comb begin
    mem_d = mem_q;
    if (clear_i) begin
      for (int i = 0; i < Depth; i++) mem_d[i] = '0;
    end else if (s1_valid_q) begin
      mem_d[s1_entry_q] = sum;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_entry_q <= '0;
      s1_data_q  <= '0;
      s1_acc_q   <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_entry_q <= s1_entry_d;
      s1_data_q  <= s1_data_d;
      s1_acc_q   <= s1_acc_d;
      for (int i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data_o = mem_q[rd_entry_i];
  assign busy_o    = s1_valid_q;

endmodule

// File: rtl/accum_bank.sv
// Crossbar receive-side accumulator bank: NumLanes accum_lane instances, drain FSM
// (idle/flush/drain/clear), drain read mux and sticky drop error.
// Build macro ACCUM_SAT_EN (in accum_lane) selects saturating accumulation.
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int unsigned NumLanes = NUM_DST,
  parameter int unsigned Depth    = 16,
  parameter int unsigned AccW     = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  data_packet_t                         in_packet [NumLanes],
  input  logic [NumLanes-1:0]                  in_valid,
  input  logic                                 xbar_busy,
  input  logic                                 drain_req,
  output logic                                 drain_valid,
  input  logic                                 drain_ready,
  output logic [$clog2(NumLanes*Depth)-1:0]    drain_index,
  output logic [AccW-1:0]                      drain_data,
  output logic                                 drain_done,
  output logic                                 idle,
  output logic                                 drop_err
);

  localparam int unsigned Total  = NumLanes * Depth;
  localparam int unsigned IdxW   = $clog2(Total);
  localparam int unsigned LaneW  = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam int unsigned EntryW = (Depth > 1) ? $clog2(Depth) : 1;

  acc_state_e        state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic              drop_err_q, drop_err_d;
  logic              accepting;
  logic              clear;
  logic [NumLanes-1:0] lane_valid;
  logic [NumLanes-1:0] lane_busy;
  logic [EntryW-1:0] lane_entry [NumLanes];
  logic [AccW-1:0]   lane_rd [NumLanes];
  logic [LaneW-1:0]  rd_lane;
  logic [EntryW-1:0] rd_entry;
  logic              unused_pkt_valid;

  assign accepting = (state_q == StIdle) || (state_q == StFlush);

  // Lane routing: entry = (index / NumLanes) mod Depth; upper index bits fall off in the cast
  always_comb begin
    unused_pkt_valid = 1'b0;
    for (int l = 0; l < NumLanes; l++) begin
      lane_valid[l]    = in_valid[l] & accepting;
      lane_entry[l]    = EntryW'(in_packet[l].index / INDEX_W'(NumLanes));
      unused_pkt_valid = unused_pkt_valid ^ in_packet[l].valid;
    end
  end

  // Drain address split: lane = g mod NumLanes, entry = g / NumLanes
  always_comb begin
    rd_lane  = LaneW'(cnt_q % IdxW'(NumLanes));
    rd_entry = EntryW'(cnt_q / IdxW'(NumLanes));
  end

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    accum_lane #(
      .Depth(Depth),
      .AccW (AccW)
    ) u_lane (
      .clk_i     (clock),
      .rst_ni    (reset),
      .valid_i   (lane_valid[l]),
      .entry_i   (lane_entry[l]),
      .data_i    (in_packet[l].data),
      .clear_i   (clear),
      .rd_entry_i(rd_entry),
      .rd_data_o (lane_rd[l]),
      .busy_o    (lane_busy[l])
    );
  end

  // FSM next state, drain stream and drop detection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clear       = 1'b0;
    drain_valid = 1'b0;
    drain_done  = 1'b0;
    drain_index = '0;
    drain_data  = '0;
    drop_err_d  = drop_err_q | ((|in_valid) & ~accepting);
    unique case (state_q)
      StIdle: begin
        if (drain_req) state_d = StFlush;
      end
      StFlush: begin
        if (!xbar_busy && (in_valid == '0) && (lane_busy == '0)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        drain_valid = 1'b1;
        drain_index = cnt_q;
        drain_data  = lane_rd[rd_lane];
        if (drain_ready) begin
          if (cnt_q == IdxW'(Total - 1)) state_d = StClear;
          else                           cnt_d   = cnt_q + 1'b1;
        end
      end
      StClear: begin
        clear      = 1'b1;
        drain_done = 1'b1;
        cnt_d      = '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign drop_err = drop_err_q;
  assign idle     = (state_q == StIdle) && (lane_busy == '0);

endmodule

// File: tb/tb_accum_bank.sv
// Self-checking bench for accum_bank: random and directed traffic against a flat
// array model of all partial sums, drained and compared beat by beat.
module tb_accum_bank;
  import accum_bank_pkg::*;

  localparam int NL    = NUM_DST;
  localparam int DEPTH = 16;
  localparam int ACCW  = 32;
  localparam int TOTAL = NL * DEPTH;
  localparam int IW    = $clog2(TOTAL);

  logic               clock = 1'b0;
  logic               reset;
  data_packet_t       in_packet [NL];
  logic [NL-1:0]      in_valid;
  logic               xbar_busy, drain_req, drain_ready;
  logic               drain_valid, drain_done, idle, drop_err;
  logic [IW-1:0]      drain_index;
  logic [ACCW-1:0]    drain_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [ACCW-1:0]   model [TOTAL];
  logic [NL-1:0]     pv;
  int                pidx [NL];
  logic [DATA_W-1:0] pdat [NL];

  accum_bank u_dut (
    .clock      (clock),
    .reset      (reset),
    .in_packet  (in_packet),
    .in_valid   (in_valid),
    .xbar_busy  (xbar_busy),
    .drain_req  (drain_req),
    .drain_valid(drain_valid),
    .drain_ready(drain_ready),
    .drain_index(drain_index),
    .drain_data (drain_data),
    .drain_done (drain_done),
    .idle       (idle),
    .drop_err   (drop_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference accumulate: signed arithmetic at full precision, then wrap or clamp
  function automatic logic [ACCW-1:0] acc_add(input logic [ACCW-1:0] a, input logic [DATA_W-1:0] d);
    longint s;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (ACCW - 1)) - 1;
    minv = -(longint'(1) <<< (ACCW - 1));
    s = longint'($signed(a)) + longint'($signed(d));
`ifdef ACCUM_SAT_EN
    if (s > maxv) s = maxv;
    if (s < minv) s = minv;
`else
    if (maxv < minv) s = 0;
`endif
    return s[ACCW-1:0];
  endfunction

  function automatic int global_idx(input int idx);
    return (idx % NL) + NL * ((idx / NL) % DEPTH);
  endfunction

  // Present pv/pidx/pdat for one cycle; all are accepted (bench only calls this in IDLE)
  task automatic apply_cycle();
    for (int l = 0; l < NL; l++) begin
      in_packet[l].valid = pv[l];
      in_packet[l].index = INDEX_W'(pidx[l]);
      in_packet[l].data  = pdat[l];
      if (pv[l]) model[global_idx(pidx[l])] = acc_add(model[global_idx(pidx[l])], pdat[l]);
    end
    in_valid = pv;
    @(posedge clock); #1;
    in_valid = '0;
    pv = '0;
  endtask

  task automatic send_one(input int idx, input logic [DATA_W-1:0] d);
    pv = '0;
    pv[idx % NL] = 1'b1;
    pidx[idx % NL] = idx;
    pdat[idx % NL] = d;
    apply_cycle();
  endtask

  task automatic random_traffic(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int l = 0; l < NL; l++) begin
        pv[l]   = 1'($urandom_range(0, 1));
        pidx[l] = l + NL * int'($urandom_range(0, 63));
        pdat[l] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom())
                                              : DATA_W'(int'($urandom_range(0, 200)) - 100);
      end
      apply_cycle();
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < TOTAL; i++) model[i] = '0;
  endtask

  task automatic do_drain(input int busy_cycles, input bit toggle_ready, input bit inject);
    int g;
    int cyc;
    bit seen;
    bit injected;
    g = 0;
    cyc = 0;
    seen = 0;
    injected = 0;
    xbar_busy = (busy_cycles > 0);
    drain_req = 1'b1;
    @(posedge clock); #1;
    drain_req = 1'b0;
    for (int i = 0; i < busy_cycles; i++) begin
      @(negedge clock);
      check_eq("busy_no_valid", 64'(drain_valid), 64'(0));
      @(posedge clock); #1;
    end
    xbar_busy = 1'b0;
    drain_ready = 1'b0;
    while (g < TOTAL && cyc < 4000) begin
      @(negedge clock);
      if (drain_valid) begin
        seen = 1;
        check_eq("drain_index", 64'(drain_index), 64'(g));
        check_eq("drain_data", 64'(drain_data), 64'(model[g]));
        if (drain_ready) g++;
      end
      @(posedge clock); #1;
      in_valid = '0;
      drain_ready = toggle_ready ? ~drain_ready : 1'($urandom_range(0, 1));
      if (inject && seen && !injected && g < TOTAL - 1) begin
        in_packet[1].index = INDEX_W'(1 + NL * 3);
        in_packet[1].data  = 32'd77;
        in_packet[1].valid = 1'b1;
        in_valid[1] = 1'b1;
        injected = 1;
      end
      cyc++;
    end
    in_valid = '0;
    check_eq("drain_beats", 64'(g), 64'(TOTAL));
    drain_ready = 1'b0;
    @(negedge clock);
    check_eq("drain_done", 64'(drain_done), 64'(1));
    check_eq("valid_after_last", 64'(drain_valid), 64'(0));
    clear_model();
    @(negedge clock);
    check_eq("done_one_pulse", 64'(drain_done), 64'(0));
    check_eq("idle_after_drain", 64'(idle), 64'(1));
    @(posedge clock); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(drain_valid), 64'(0));
    check_eq({tag, "_done"}, 64'(drain_done), 64'(0));
    check_eq({tag, "_drop"}, 64'(drop_err), 64'(0));
    check_eq({tag, "_idle"}, 64'(idle), 64'(1));
    check_eq({tag, "_index"}, 64'(drain_index), 64'(0));
    check_eq({tag, "_data"}, 64'(drain_data), 64'(0));
  endtask

  initial begin
    reset = 1'b0;
    in_valid = '0;
    xbar_busy = 1'b0;
    drain_req = 1'b0;
    drain_ready = 1'b0;
    pv = '0;
    for (int l = 0; l < NL; l++) begin
      pidx[l] = 0;
      pdat[l] = '0;
      in_packet[l] = '0;
    end
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst_init");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed: three hits on index 5 (lane 1, entry 1) -> 6
    send_one(5, 32'd3);
    send_one(5, -32'sd7);
    send_one(5, 32'd10);
    do_drain(0, 0, 0);

    // Same entry every cycle (forwarding), then drain held off by busy with toggled ready
    for (int i = 0; i < 8; i++) send_one(2 + NL * 7, 32'd1);
    do_drain(5, 1, 0);

    // Overflow boundaries, plus upper index bits that must be ignored
    send_one(0, 32'h7fff_ffff);
    send_one(0, 32'd1);
    send_one(4, 32'h8000_0000);
    send_one(4, 32'hffff_ffff);
    send_one(3 + NL * DEPTH * 2, 32'd9);
    random_traffic(40);
    do_drain(0, 0, 0);

    random_traffic(60);
    do_drain(2, 0, 0);

    // Reset in the middle of traffic, then drain returns zeros
    random_traffic(6);
    for (int l = 0; l < NL; l++) begin
      in_packet[l].index = INDEX_W'(l);
      in_packet[l].data  = 32'd5;
    end
    in_valid = '1;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clock); #1;
    in_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    clear_model();
    @(posedge clock); #1;
    do_drain(0, 0, 0);

    // Packet during drain is dropped; drop_err is sticky
    check_eq("drop_before", 64'(drop_err), 64'(0));
    random_traffic(10);
    do_drain(0, 0, 1);
    check_eq("drop_set", 64'(drop_err), 64'(1));
    do_drain(0, 1, 0);
    check_eq("drop_sticky", 64'(drop_err), 64'(1));

    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("drop_cleared", 64'(drop_err), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
